if_id_fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. Holds the PC and drives the instruction-memory address. It captures fetched instructions into IF/ID and applies the hazard unit's ID_Stall and Flush_IF_ID. It also takes branch/jump/JR redirects resolved in MEM, and keeps saturating performance counters for fetched, stalled and flushed cycles.

---
 rtl/if_id_fetch_unit_pkg.sv | 26 ++
 rtl/if_id_fetch_unit_sat_counter.sv | 28 ++
 rtl/if_id_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_if_id_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_fetch_unit_pkg.sv
// Core-wide definitions shared by the fetch stage and its neighbours.
//   - PCSrc encodings driven by the MEM stage redirect logic
//   - canonical NOP encoding (sll $0,$0,0)
//   - fetch-state encodings reported on FetchState
//   - word-alignment helper for redirect targets
package if_id_fetch_unit_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;  // sequential PC+4
    localparam logic [1:0] PCSRC_BR  = 2'b01;  // taken branch
    localparam logic [1:0] PCSRC_J   = 2'b10;  // j / jal
    localparam logic [1:0] PCSRC_JR  = 2'b11;  // jr (register target)

    localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_RUN        = 2'd0,
        FS_STALLED    = 2'd1,
        FS_REDIRECTED = 2'd2
    } fetch_state_e;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_fetch_unit_sat_counter.sv
// Saturating up-counter used for the fetch-stage performance statistics.
// Ports:
//   Clk    in   clock, rising edge
//   Reset  in   asynchronous active-high reset, clears the count
//   inc    in   increment request for this cycle
//   count  out  W-bit count, sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/if_id_fetch_unit.sv
// Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
// Holds the PC, drives the (combinational) instruction memory, captures the
// fetched word into IF/ID and applies hazard-unit stall/flush and MEM-stage
// redirects. Keeps saturating counters of fetched, stalled and flushed cycles.
// Ports:
//   Clk, Reset                      clock (rising edge), async active-high reset
//   ID_Stall, Flush_IF_ID           hazard-unit hold / NOP-injection requests
//   MEM_PCSrc                       redirect select (seq / branch / jump / jr)
//   MEM_BranchTarget/JumpTarget/JRTarget  candidate redirect targets
//   IMem_Addr, IMem_Instr           instruction memory address / returned word
//   IF_PC                           current PC
//   ID_Instr, ID_PCPlus4, ID_Valid  IF/ID register contents
//   FetchState                      RUN / STALLED / REDIRECTED
//   Misaligned                      sticky flag: a redirect target was not word aligned
//   Stat_Fetched/StallCycles/FlushCycles  saturating performance counters
module if_id_fetch_unit
    import if_id_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ID_Stall,
    input  logic             Flush_IF_ID,
    input  logic [1:0]       MEM_PCSrc,
    input  logic [31:0]      MEM_BranchTarget,
    input  logic [31:0]      MEM_JumpTarget,
    input  logic [31:0]      MEM_JRTarget,
    output logic [31:0]      IMem_Addr,
    input  logic [31:0]      IMem_Instr,
    output logic [31:0]      IF_PC,
    output logic [31:0]      ID_Instr,
    output logic [31:0]      ID_PCPlus4,
    output logic             ID_Valid,
    output logic [1:0]       FetchState,
    output logic             Misaligned,
    output logic [CNT_W-1:0] Stat_Fetched,
    output logic [CNT_W-1:0] Stat_StallCycles,
    output logic [CNT_W-1:0] Stat_FlushCycles
);

    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  pcp4_reg, pcp4_next;
    logic         valid_reg, valid_next;
    fetch_state_e state_reg, state_next;
    logic         misaligned_reg, misaligned_next;

    logic         inc_fetched;
    logic         inc_stall;
    logic         inc_flush;

    logic [31:0]  pc_plus4;
    logic [31:0]  raw_target;
    logic         redirect;

    // Wraps naturally modulo 2^32.
    assign pc_plus4 = pc_reg + 32'd4;
    assign redirect = (MEM_PCSrc != PCSRC_SEQ);

    // Next-PC target mux; the sequential encoding never reaches this value.
    always_comb begin
        raw_target = MEM_BranchTarget;
        case (MEM_PCSrc)
            PCSRC_BR: raw_target = MEM_BranchTarget;
            PCSRC_J:  raw_target = MEM_JumpTarget;
            PCSRC_JR: raw_target = MEM_JRTarget;
            default:  raw_target = MEM_BranchTarget;
        endcase
    end

    // Next-state logic: redirect beats stall, stall beats flush, flush beats fetch.
    always_comb begin
        pc_next         = pc_reg;
        instr_next      = instr_reg;
        pcp4_next       = pcp4_reg;
        valid_next      = valid_reg;
        state_next      = FS_RUN;
        misaligned_next = misaligned_reg;
        inc_fetched     = 1'b0;
        inc_stall       = 1'b0;
        inc_flush       = 1'b0;

        if (redirect) begin
            pc_next    = align_word(raw_target);
            instr_next = NOP_INSTR;
            pcp4_next  = 32'd0;
            valid_next = 1'b0;
            state_next = FS_REDIRECTED;
            inc_flush  = 1'b1;
            if (raw_target[1:0] != 2'b00) begin
                misaligned_next = 1'b1;
            end
        end else if (ID_Stall) begin
            state_next = FS_STALLED;
            inc_stall  = 1'b1;
            // A flush during a stall still squashes IF/ID, but the PC holds.
            if (Flush_IF_ID) begin
                instr_next = NOP_INSTR;
                pcp4_next  = 32'd0;
                valid_next = 1'b0;
                inc_flush  = 1'b1;
            end
        end else if (Flush_IF_ID) begin
            // The word fetched this cycle is discarded but fetch moves on.
            pc_next    = pc_plus4;
            instr_next = NOP_INSTR;
            pcp4_next  = 32'd0;
            valid_next = 1'b0;
            inc_flush  = 1'b1;
        end else begin
            pc_next     = pc_plus4;
            instr_next  = IMem_Instr;
            pcp4_next   = pc_plus4;
            valid_next  = 1'b1;
            inc_fetched = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_reg         <= RESET_PC;
            instr_reg      <= NOP_INSTR;
            pcp4_reg       <= 32'd0;
            valid_reg      <= 1'b0;
            state_reg      <= FS_RUN;
            misaligned_reg <= 1'b0;
        end else begin
            pc_reg         <= pc_next;
            instr_reg      <= instr_next;
            pcp4_reg       <= pcp4_next;
            valid_reg      <= valid_next;
            state_reg      <= state_next;
            misaligned_reg <= misaligned_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_fetched (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (inc_fetched),
        .count (Stat_Fetched)
    );

    sat_counter #(.W(CNT_W)) u_cnt_stall (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (inc_stall),
        .count (Stat_StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (inc_flush),
        .count (Stat_FlushCycles)
    );

    assign IMem_Addr  = pc_reg;
    assign IF_PC      = pc_reg;
    assign ID_Instr   = instr_reg;
    assign ID_PCPlus4 = pcp4_reg;
    assign ID_Valid   = valid_reg;
    assign FetchState = state_reg;
    assign Misaligned = misaligned_reg;

endmodule

// File: tb/tb_if_id_fetch_unit.sv
// Bench for if_id_fetch_unit: a default-parameter instance checked every cycle
// against a behavioural model, plus directed literal checks; a second instance
// with RESET_PC=FFFF_FFFC and 2-bit counters covers wrap, saturation and
// asynchronous reset.
module tb_if_id_fetch_unit;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    // Combinational instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h2008_0005;
        if (addr == 32'h4) return 32'h2009_0003;
        return 32'h8C00_0000 | addr;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- instance A (default parameters) ----------------
    logic        rst_a = 1'b0;
    logic        a_stall = 1'b0, a_flush = 1'b0;
    logic [1:0]  a_pcsrc = 2'b00;
    logic [31:0] a_br = '0, a_j = '0, a_jr = '0;
    logic [31:0] a_addr, a_instr, a_pc, a_id_instr, a_id_pcp4;
    logic        a_id_valid, a_mis;
    logic [1:0]  a_state;
    logic [31:0] a_fet, a_stc, a_flc;

    assign a_instr = mem_word(a_addr);

    if_id_fetch_unit dut_a (
        .Clk(Clk), .Reset(rst_a), .ID_Stall(a_stall), .Flush_IF_ID(a_flush),
        .MEM_PCSrc(a_pcsrc), .MEM_BranchTarget(a_br), .MEM_JumpTarget(a_j),
        .MEM_JRTarget(a_jr), .IMem_Addr(a_addr), .IMem_Instr(a_instr),
        .IF_PC(a_pc), .ID_Instr(a_id_instr), .ID_PCPlus4(a_id_pcp4),
        .ID_Valid(a_id_valid), .FetchState(a_state), .Misaligned(a_mis),
        .Stat_Fetched(a_fet), .Stat_StallCycles(a_stc), .Stat_FlushCycles(a_flc)
    );

    // ---------------- instance B (wrap / saturation) ----------------
    logic        rst_b = 1'b0;
    logic        b_stall = 1'b0, b_flush = 1'b0;
    logic [1:0]  b_pcsrc = 2'b00;
    logic [31:0] b_br = '0, b_j = '0, b_jr = '0;
    logic [31:0] b_addr, b_instr, b_pc, b_id_instr, b_id_pcp4;
    logic        b_id_valid, b_mis;
    logic [1:0]  b_state;
    logic [1:0]  b_fet, b_stc, b_flc;

    assign b_instr = mem_word(b_addr);

    if_id_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_b (
        .Clk(Clk), .Reset(rst_b), .ID_Stall(b_stall), .Flush_IF_ID(b_flush),
        .MEM_PCSrc(b_pcsrc), .MEM_BranchTarget(b_br), .MEM_JumpTarget(b_j),
        .MEM_JRTarget(b_jr), .IMem_Addr(b_addr), .IMem_Instr(b_instr),
        .IF_PC(b_pc), .ID_Instr(b_id_instr), .ID_PCPlus4(b_id_pcp4),
        .ID_Valid(b_id_valid), .FetchState(b_state), .Misaligned(b_mis),
        .Stat_Fetched(b_fet), .Stat_StallCycles(b_stc), .Stat_FlushCycles(b_flc)
    );

    // ---------------- behavioural model of instance A ----------------
    localparam longint CNT_MAX = 64'hFFFF_FFFF;
    logic [31:0] m_pc, m_instr, m_pcp4;
    logic        m_valid, m_mis;
    logic [1:0]  m_state;
    longint      m_fet, m_stc, m_flc;
    logic [31:0] a_tgt;

    assign a_tgt = (a_pcsrc == 2'd1) ? a_br : (a_pcsrc == 2'd2) ? a_j : a_jr;

    function automatic longint bump(input longint v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    always @(posedge Clk or posedge rst_a) begin
        if (rst_a) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_pcp4 <= 32'h0; m_valid <= 1'b0;
            m_state <= 2'd0; m_mis <= 1'b0; m_fet <= 0; m_stc <= 0; m_flc <= 0;
        end else if (a_pcsrc != 2'd0) begin
            m_pc <= a_tgt - (a_tgt % 4);
            if (a_tgt % 4 != 0) m_mis <= 1'b1;
            m_instr <= 32'h0; m_pcp4 <= 32'h0; m_valid <= 1'b0;
            m_state <= 2'd2; m_flc <= bump(m_flc);
        end else if (a_stall) begin
            m_state <= 2'd1; m_stc <= bump(m_stc);
            if (a_flush) begin
                m_instr <= 32'h0; m_pcp4 <= 32'h0; m_valid <= 1'b0;
                m_flc <= bump(m_flc);
            end
        end else if (a_flush) begin
            m_pc <= m_pc + 32'd4;
            m_instr <= 32'h0; m_pcp4 <= 32'h0; m_valid <= 1'b0;
            m_state <= 2'd0; m_flc <= bump(m_flc);
        end else begin
            m_instr <= mem_word(m_pc); m_pcp4 <= m_pc + 32'd4; m_pc <= m_pc + 32'd4;
            m_valid <= 1'b1; m_state <= 2'd0; m_fet <= bump(m_fet);
        end
    end

    // Every-cycle compare of instance A against the model.
    always @(negedge Clk) begin
        if (cmp_en) begin
            check("model IMem_Addr",   a_addr,     m_pc);
            check("model IF_PC",       a_pc,       m_pc);
            check("model ID_Instr",    a_id_instr, m_instr);
            check("model ID_PCPlus4",  a_id_pcp4,  m_pcp4);
            check("model ID_Valid",    {31'b0, a_id_valid}, {31'b0, m_valid});
            check("model FetchState",  {30'b0, a_state},    {30'b0, m_state});
            check("model Misaligned",  {31'b0, a_mis},      {31'b0, m_mis});
            check("model Stat_Fetched",     a_fet, m_fet[31:0]);
            check("model Stat_StallCycles", a_stc, m_stc[31:0]);
            check("model Stat_FlushCycles", a_flc, m_flc[31:0]);
        end
    end

    task automatic cyc(input string label);
        @(posedge Clk);
        @(negedge Clk);
        $display("step %-14s pcA=%h idA=%h vA=%0d st=%0d | pcB=%h fetB=%0d",
                 label, a_pc, a_id_instr, a_id_valid, a_state, b_pc, b_fet);
    endtask

    initial begin
        #1 rst_a = 1'b1; rst_b = 1'b1;
        #2 cmp_en = 1'b1;
        check("rst IF_PC",      a_pc, 32'h0);
        check("rst ID_Instr",   a_id_instr, 32'h0);
        check("rst ID_PCPlus4", a_id_pcp4, 32'h0);
        check("rst ID_Valid",   {31'b0, a_id_valid}, 32'd0);
        check("rst FetchState", {30'b0, a_state}, 32'd0);
        check("rst counters",   a_fet | a_stc | a_flc, 32'd0);
        check("rst B IF_PC",    b_pc, 32'hFFFF_FFFC);

        @(negedge Clk);
        rst_a = 1'b0;

        // Plain fetch from reset.
        cyc("fetch1");
        check("t1 ID_Instr",   a_id_instr, 32'h2008_0005);
        check("t1 ID_PCPlus4", a_id_pcp4, 32'h4);
        check("t1 ID_Valid",   {31'b0, a_id_valid}, 32'd1);
        cyc("fetch2");
        check("t1 ID_Instr 2", a_id_instr, 32'h2009_0003);
        check("t1 IF_PC 2",    a_pc, 32'h8);
        check("t1 Fetched 2",  a_fet, 32'd2);
        cyc("fetch3");
        cyc("fetch4");
        check("t2 PC start", a_pc, 32'h10);

        // Three-cycle stall at 0x10.
        a_stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("stall");
        check("t2 PC held",      a_pc, 32'h10);
        check("t2 ID_Instr held", a_id_instr, 32'h8C00_000C);
        check("t2 FetchState",   {30'b0, a_state}, 32'd1);
        check("t2 StallCycles",  a_stc, 32'd3);
        a_stall = 1'b0;
        cyc("release");
        check("t2 PC after", a_pc, 32'h14);
        for (int i = 0; i < 3; i++) cyc("fetch");
        check("t3 PC start", a_pc, 32'h20);

        // Stall together with flush.
        a_stall = 1'b1; a_flush = 1'b1;
        cyc("stall+flush");
        a_stall = 1'b0; a_flush = 1'b0;
        check("t3 ID_Instr",    a_id_instr, 32'h0);
        check("t3 ID_Valid",    {31'b0, a_id_valid}, 32'd0);
        check("t3 PC held",     a_pc, 32'h20);
        check("t3 StallCycles", a_stc, 32'd4);
        check("t3 FlushCycles", a_flc, 32'd1);

        // Flush alone: fetch advances, word dropped.
        a_flush = 1'b1;
        cyc("flush");
        a_flush = 1'b0;
        check("flush PC",       a_pc, 32'h24);
        check("flush ID_Valid", {31'b0, a_id_valid}, 32'd0);

        // Branch redirect wins over stall.
        a_pcsrc = 2'b01; a_br = 32'h40; a_stall = 1'b1;
        cyc("branch");
        a_pcsrc = 2'b00; a_stall = 1'b0;
        check("t4 PC",          a_pc, 32'h40);
        check("t4 ID_Valid",    {31'b0, a_id_valid}, 32'd0);
        check("t4 FetchState",  {30'b0, a_state}, 32'd2);
        check("t4 StallCycles", a_stc, 32'd4);
        cyc("fetch tgt");
        check("t4 ID_Instr",   a_id_instr, 32'h8C00_0040);
        check("t4 ID_PCPlus4", a_id_pcp4, 32'h44);

        // Misaligned jr, then aligned jump.
        a_pcsrc = 2'b11; a_jr = 32'h0000_0102;
        cyc("jr");
        check("t5 PC jr",      a_pc, 32'h100);
        check("t5 Misaligned", {31'b0, a_mis}, 32'd1);
        a_pcsrc = 2'b10; a_j = 32'h200;
        cyc("jump");
        a_pcsrc = 2'b00;
        check("t5 PC j",           a_pc, 32'h200);
        check("t5 Misaligned kept", {31'b0, a_mis}, 32'd1);
        cyc("fetch");
        check("t5 ID_Instr",   a_id_instr, 32'h8C00_0200);
        check("end Fetched",   a_fet, 32'd10);
        check("end FlushCyc",  a_flc, 32'd5);

        // Instance B: PC wrap and 2-bit counter saturation.
        rst_b = 1'b0;
        cyc("B fetch1");
        check("t6 PC wrap",      b_pc, 32'h0);
        check("t6 PCPlus4 wrap", b_id_pcp4, 32'h0);
        check("t6 ID_Instr",     b_id_instr, 32'hFFFF_FFFC);
        check("t6 Fetched 1",    {30'b0, b_fet}, 32'd1);
        cyc("B fetch2");
        check("t6 Fetched 2",    {30'b0, b_fet}, 32'd2);
        cyc("B fetch3");
        check("t6 Fetched 3",    {30'b0, b_fet}, 32'd3);
        cyc("B fetch4");
        cyc("B fetch5");
        check("t6 Fetched sat",  {30'b0, b_fet}, 32'd3);
        check("t6 PC 5",         b_pc, 32'h10);

        // Asynchronous reset between edges.
        @(posedge Clk);
        #2 rst_b = 1'b1;
        #1;
        check("t6 async PC",      b_pc, 32'hFFFF_FFFC);
        check("t6 async Fetched", {30'b0, b_fet}, 32'd0);
        check("t6 async Valid",   {31'b0, b_id_valid}, 32'd0);
        check("t6 async Instr",   b_id_instr, 32'h0);
        check("t6 async PCPlus4", b_id_pcp4, 32'h0);

        @(negedge Clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
